// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// State values are visible on the debug port, so they are fixed explicitly.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_sup_state_e;

  // Width of one counter shared by every timed state: it must hold the largest terminal count.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single level signal crossing into i_clk.
// RESET_VAL sets what the consumer sees while the domain is held in reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Brings up the rPLL on the board clock: reset pulse, lock wait with timeout, lock
// qualification, then releases the pixel-domain reset request; retries and parks in FAIL.
//
// state      | meaning
// PLL_RST    | pll_reset high for RST_PULSE_CYC cycles
// WAIT_LOCK  | waiting for synced lock, LOCK_TIMEOUT_CYC budget per attempt
// STABLE     | lock must hold LOCK_STABLE_CYC consecutive cycles
// RUN        | locked, downstream reset released
// FAIL       | MAX_RETRY attempts failed, held until restart or arst_n
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter  int RST_PULSE_CYC    = 16,
  parameter  int LOCK_TIMEOUT_CYC = 27000,
  parameter  int LOCK_STABLE_CYC  = 256,
  parameter  int MAX_RETRY        = 3,
  localparam int RETRY_W          = $clog2(MAX_RETRY + 1)
) (
  input  logic               clk_ext,
  input  logic               arst_n,
  input  logic               pll_lock,
  input  logic               restart,
  output logic               pll_reset,
  output logic               sys_rst_n,
  output logic               locked,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   STAB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  logic                 w_lock_s;
  pll_sup_state_e       r_state;
  pll_sup_state_e       w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_cnt_clr;
  logic [RETRY_W-1:0]   r_retry;
  logic [RETRY_W-1:0]   w_retry_nxt;
  logic [RETRY_W-1:0]   w_retry_inc;
  logic                 r_pll_reset;
  logic                 r_sys_rst_n;
  logic                 r_locked;
  logic                 r_fail;
  logic                 w_pll_reset_nxt;
  logic                 w_sys_rst_n_nxt;
  logic                 w_locked_nxt;
  logic                 w_fail_nxt;

  sync_2ff #(
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .i_clk   (clk_ext),
    .i_rst_n (arst_n),
    .i_d     (pll_lock),
    .o_q     (w_lock_s)
  );

  // State, counter, retry count and the registered outputs all load together.
  always_ff @(posedge clk_ext or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= ST_PLL_RST;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_pll_reset <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_locked    <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_retry     <= w_retry_nxt;
      r_pll_reset <= w_pll_reset_nxt;
      r_sys_rst_n <= w_sys_rst_n_nxt;
      r_locked    <= w_locked_nxt;
      r_fail      <= w_fail_nxt;
      if (w_cnt_clr)
        r_cnt <= '0;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_retry_inc = (r_retry == RETRY_MAX) ? r_retry : r_retry + RETRY_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    if (restart) begin
      w_state_nxt = ST_PLL_RST;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_cnt == RST_LAST)
            w_state_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_state_nxt = ST_STABLE;
          end else if (r_cnt == TO_LAST) begin
            w_retry_nxt = w_retry_inc;
            w_state_nxt = (w_retry_inc == RETRY_MAX) ? ST_FAIL : ST_PLL_RST;
          end
        end
        ST_STABLE: begin
          // A dropped lock is not a failed attempt: go back and wait again.
          if (!w_lock_s) begin
            w_state_nxt = ST_WAIT_LOCK;
          end else if (r_cnt == STAB_LAST) begin
            w_state_nxt = ST_RUN;
            w_retry_nxt = '0;
          end
        end
        ST_RUN: begin
          if (!w_lock_s)
            w_state_nxt = ST_PLL_RST;
        end
        ST_FAIL: begin
          w_state_nxt = ST_FAIL;
        end
        default: begin
          w_state_nxt = ST_PLL_RST;
        end
      endcase
    end
  end

  // Restart re-enters PLL_RST from PLL_RST too, so it must also clear the counter.
  assign w_cnt_clr = (w_state_nxt != r_state) || restart;

  always_comb begin
    w_pll_reset_nxt = (w_state_nxt == ST_PLL_RST);
    w_sys_rst_n_nxt = (w_state_nxt == ST_RUN);
    w_locked_nxt    = (w_state_nxt == ST_RUN);
    w_fail_nxt      = (w_state_nxt == ST_FAIL);
  end

  assign pll_reset = r_pll_reset;
  assign sys_rst_n = r_sys_rst_n;
  assign locked    = r_locked;
  assign fail      = r_fail;
  assign retry_cnt = r_retry;
  assign state     = r_state;

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the GoWin rPLL that generates the HDMI serial/pixel clocks, running on the free-running 27 MHz board clock. Pulses the PLL reset, waits for lock with a timeout, requires lock to be stable before releasing the downstream pixel-domain reset request, and restarts the PLL on loss of lock. After a bounded number of failed attempts it parks in a sticky fail state. Sits between the board clock pin and the PLL/CLKDIV/reset-synchronizer wrapper.

## Interface
- RST_PULSE_CYC, 16: PLL reset pulse width, clk_ext cycles (≥1)
- LOCK_TIMEOUT_CYC, 27000: max cycles waiting for lock per attempt (1 ms @ 27 MHz)
- LOCK_STABLE_CYC, 256: consecutive synced-lock cycles required before release (≥1)
- MAX_RETRY, 3: failed attempts tolerated before FAIL (≥1)
- clk_ext  in  1  27 MHz board clock; sole clock of the block
- arst_n  in  1  asynchronous, active-low reset
- pll_lock  in  1  raw rPLL LOCK, asynchronous to clk_ext
- restart  in  1  single-cycle request to re-run the full sequence (also clears FAIL)
- pll_reset  out  1  drives rPLL RESET, active-high
- sys_rst_n  out  1  downstream reset request, active-low; resynchronized by consumer into clk_pix
- locked  out  1  high only in RUN
- fail  out  1  sticky, high only in FAIL
- retry_cnt  out  $clog2(MAX_RETRY+1)  attempts failed since last success/restart
- state  out  3  current state encoding, for debug

## Operation
- pll_lock passes a 2-FF synchronizer → lock_s; FSM uses lock_s only.
- States: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4. Single shared cycle counter cnt, cleared on every state entry.
- PLL_RST: pll_reset=1, sys_rst_n=0. After RST_PULSE_CYC cycles → WAIT_LOCK.
- WAIT_LOCK: pll_reset=0, sys_rst_n=0. lock_s=1 → STABLE. cnt reaches LOCK_TIMEOUT_CYC-1 with lock_s=0 → retry_cnt+1; if new value == MAX_RETRY → FAIL else → PLL_RST.
- STABLE: sys_rst_n=0. lock_s=0 → WAIT_LOCK (cnt cleared, no retry increment, timeout restarts). LOCK_STABLE_CYC consecutive lock_s=1 cycles (counting entry cycle) → RUN; retry_cnt cleared on entry to RUN.
- RUN: sys_rst_n=1, locked=1. lock_s=0 → PLL_RST, sys_rst_n deasserted to 0 in the same cycle the FSM leaves RUN (registered output, falls on the first edge after lock_s drops).
- FAIL: pll_reset=0, sys_rst_n=0, fail=1; held until restart or arst_n.
- restart=1 in any state → PLL_RST next cycle, retry_cnt=0, fail cleared. restart has priority over every other transition.
- Counters saturate; no wrap. cnt width $clog2 of max(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC).

## Timing
- Reset values (arst_n=0): state=PLL_RST, pll_reset=1, sys_rst_n=0, locked=0, fail=0, retry_cnt=0, cnt=0, synchronizer flops=0.
- arst_n deassertion mid-sequence: full restart from PLL_RST; no partial state retained.
- All outputs registered; each changes on the clk_ext edge that enters the state it belongs to.
- Lock-to-release latency (clean lock): 2 (sync) + LOCK_STABLE_CYC + 1 cycles from pll_lock rise to sys_rst_n=1.
- Lock-loss-to-reset latency: 2 sync + 1 = 3 cycles from pll_lock fall to sys_rst_n=0.
- Glitch on pll_lock shorter than 1 cycle may be missed; in STABLE any sampled drop restarts stability count.

## Structure
- Shared package pll_sup_pkg: state enum pll_sup_state_e (3-bit, values above), counter-width helper function.
- One sub-module: sync_2ff (generic 2-flop bit synchronizer, async active-low reset, reset value parameter), reusable for other CDC bits.
- FSM, counter and retry logic in the top module.

## Test plan
- Clean bring-up: release arst_n, raise pll_lock 100 cycles after pll_reset falls → pll_reset high exactly 16 cycles, sys_rst_n rises 2+256+1 cycles after pll_lock, locked=1, retry_cnt=0.
- Never-lock: pll_lock held 0 → three PLL_RST pulses spaced 16+27000 cycles, retry_cnt 1,2,3, fail=1 and pll_reset=0 thereafter; restart → PLL_RST, fail=0, retry_cnt=0.
- Chatter in STABLE: pll_lock drops for 3 cycles at stability count 200 → back to WAIT_LOCK, no retry increment, sys_rst_n stays 0; release only after full 256 clean cycles.
- Loss of lock in RUN: drop pll_lock → sys_rst_n=0 and locked=0 within 3 cycles, pll_reset pulse follows, re-lock restores RUN.
- Second attempt success: no lock on attempt 1, lock on attempt 2 → retry_cnt=1 during attempt, cleared to 0 on RUN entry.
- arst_n asserted in RUN and in STABLE → all outputs at reset values asynchronously; sequence restarts from PLL_RST on release.
